// File: rtl/sequential_addsub.sv
// -----------------------------------------------------------------------------
// sequential_addsub
//
// Multi-cycle adder/subtractor. An operation is accepted in IDLE, then
// processed SLICE bits per clock (LSB slice first) with the inter-slice carry
// kept in a register. The visible result and flags only change on the edge
// that processes the final slice. A one-cycle done pulse follows.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   SLICE  bits processed per clock (1..WIDTH, WIDTH divisible by SLICE)
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   start         operation request (accepted only in IDLE)
//   mode          1 = a+b, 0 = a-b (sampled with start)
//   a, b          operands (sampled with start)
//   result        registered sum/difference modulo 2^WIDTH
//   carry_borrow  add: carry out of MSB; subtract: borrow (a < b unsigned)
//   signed_ovf    two's-complement overflow of the operation
//   zero          result == 0
//   busy          high in RUN and DONE
//   done          one-cycle completion pulse (DONE state)
// -----------------------------------------------------------------------------
module sequential_addsub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow,
    output logic             signed_ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic             mode_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    // Working copy of the result; slices land here so the visible result
    // stays untouched until the operation completes.
    logic [WIDTH-1:0] acc_reg;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] b_eff;
    logic [SLICE:0]   slice_full;
    logic             last_slice;
    logic             same_sign;
    logic             ovf_next;
    wire  [WIDTH-1:0] final_value;

    // Select the operand slice addressed by the counter.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_reg == CNT_W'(i)) begin
                a_slice = a_reg[i*SLICE +: SLICE];
                b_slice = b_reg[i*SLICE +: SLICE];
            end
        end
    end

    // Subtraction is a + ~b + 1; the +1 comes from the carry loaded at start.
    assign b_eff      = mode_reg ? b_slice : ~b_slice;
    assign slice_full = {1'b0, a_slice} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_reg};
    assign last_slice = (cnt_reg == LAST);

    // Working value with the current slice merged in at its bit position.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign final_value[gi*SLICE +: SLICE] =
                (cnt_reg == CNT_W'(gi)) ? slice_full[SLICE-1:0]
                                        : acc_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    // Overflow: operand signs equal (add) or differ (subtract), and the
    // result sign differs from a's sign.
    assign same_sign = ~(a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
    assign ovf_next  = (mode_reg ? same_sign : ~same_sign) &
                       (final_value[WIDTH-1] ^ a_reg[WIDTH-1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            carry_reg    <= 1'b0;
            mode_reg     <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            acc_reg      <= '0;
            result       <= '0;
            carry_borrow <= 1'b0;
            signed_ovf   <= 1'b0;
            zero         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        mode_reg  <= mode;
                        cnt_reg   <= '0;
                        carry_reg <= ~mode;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg   <= final_value;
                    carry_reg <= slice_full[SLICE];
                    if (last_slice) begin
                        cnt_reg      <= '0;
                        state_reg    <= DONE;
                        result       <= final_value;
                        carry_borrow <= mode_reg ? slice_full[SLICE] : ~slice_full[SLICE];
                        signed_ovf   <= ovf_next;
                        zero         <= (final_value == '0);
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    // start is deliberately not examined here
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Decoded straight from the state register so reset clears them at once.
    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);

endmodule
